// File: rtl/ps2_tx_axis.sv
// ps2_tx_axis: host-to-device PS/2 command transmitter with an AXI-Stream
// byte input. A byte is sent by inhibiting the clock, making a request-to-send,
// then shifting start/data/parity/stop bits on device-generated falling edges,
// and finally sampling the device ACK.
// Optional feature: define PS2_TX_RESEND_EN to retry a NACKed byte once.
module ps2_tx_axis #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o
);

    localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;       // inhibit length, then timeout
    logic [3:0]       r_edge_cnt;
    logic [7:0]       r_byte;
    logic             r_tready;
    logic             r_busy;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_ack;
    logic             r_err;
`ifdef PS2_TX_RESEND_EN
    logic             r_resent;    // this byte has already been retried once
    logic             r_retry;     // WAIT_IDLE should restart from INHIBIT
`endif

    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;
    logic w_clk_fall;

    // Bit driven after falling edge idx+1: data LSB first, odd parity, then stop (1).
    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
        logic b;
        if (idx < 4'd8)
            b = d[idx[2:0]];
        else if (idx == 4'd8)
            b = ~^d;
        else
            b = 1'b1;
        return b;
    endfunction

    // Two-flop synchronizers for the raw lines plus a delayed clock for edge detect;
    // reset to the idle (high) line level so no false edge follows reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;

    // Command byte capture on the AXI-Stream handshake (data path, no reset).
    always_ff @(posedge clk_i) begin
        if (s_axis_tvalid_i && r_tready)
            r_byte <= s_axis_tdata_i;
    end

    // Transfer FSM with registered line enables and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            r_resent   <= 1'b0;
            r_retry    <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tready <= 1'b1;
                    r_busy   <= 1'b0;
                    if (s_axis_tvalid_i && r_tready) begin
                        r_state   <= INHIBIT;
                        r_tready  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_cnt     <= '0;
`ifdef PS2_TX_RESEND_EN
                        r_resent  <= 1'b0;
                        r_retry   <= 1'b0;
`endif
                    end
                end
                INHIBIT: begin
                    if (r_cnt == INH_LAST) begin
                        r_state   <= REQ;
                        r_data_oe <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                REQ: begin
                    // Release the clock while holding data low: this is the start bit.
                    r_state    <= SHIFT;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b1;
                    r_cnt      <= '0;
                    r_edge_cnt <= '0;
                end
                SHIFT, ACK: begin
                    if (r_cnt == TO_LAST) begin
                        r_state    <= WAIT_IDLE;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_err      <= 1'b1;
                        r_cnt      <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_clk_fall && r_state == SHIFT) begin
                            r_data_oe  <= ~frame_bit(r_byte, r_edge_cnt);
                            r_edge_cnt <= r_edge_cnt + 1'b1;
                            if (r_edge_cnt == 4'd9)
                                r_state <= ACK;
                        end else if (w_clk_fall) begin
                            r_state    <= WAIT_IDLE;
                            r_cnt      <= '0;
                            r_edge_cnt <= '0;
                            if (!r_dat_sync) begin
                                r_ack <= 1'b1;
                            end else begin
`ifdef PS2_TX_RESEND_EN
                                if (r_resent) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_resent <= 1'b1;
                                    r_retry  <= 1'b1;
                                end
`else
                                r_err <= 1'b1;
`endif
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (r_clk_sync && r_dat_sync) begin
`ifdef PS2_TX_RESEND_EN
                        if (r_retry) begin
                            r_state   <= INHIBIT;
                            r_retry   <= 1'b0;
                            r_clk_oe  <= 1'b1;
                            r_data_oe <= 1'b0;
                            r_cnt     <= '0;
                        end else begin
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                            r_tready <= 1'b1;
                        end
`else
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_tready <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_tready  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready_o = r_tready;
    assign busy_o          = r_busy;
    assign ps2_clk_oe_o    = r_clk_oe;
    assign ps2_data_oe_o   = r_data_oe;
    assign ack_o           = r_ack;
    assign err_o           = r_err;

endmodule

// File: tb/tb_ps2_tx_axis.sv
// tb_ps2_tx_axis: directed + randomized bench for ps2_tx_axis with a behavioural
// open-drain PS/2 device that generates the clock, samples the frame and ACKs/NACKs.
module tb_ps2_tx_axis;

    localparam int INH = 2000;
    localparam int TO  = 1500;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       s_axis_tvalid_i = 1'b0;
    logic       s_axis_tready_o;
    logic [7:0] s_axis_tdata_i = 8'h00;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe_o;
    logic       ps2_data_oe_o;
    logic       busy_o;
    logic       ack_o;
    logic       err_o;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_ack = 0;
    int n_err = 0;
    int n_rdy_busy = 0;
    int acc_n = 0;
    logic [7:0] acc_last = 8'h00;

    ps2_tx_axis #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .s_axis_tvalid_i(s_axis_tvalid_i),
        .s_axis_tready_o(s_axis_tready_o),
        .s_axis_tdata_i (s_axis_tdata_i),
        .ps2_clk_i      (ps2_clk_i),
        .ps2_data_i     (ps2_data_i),
        .ps2_clk_oe_o   (ps2_clk_oe_o),
        .ps2_data_oe_o  (ps2_data_oe_o),
        .busy_o         (busy_o),
        .ack_o          (ack_o),
        .err_o          (err_o)
    );

    // Open-drain wired-AND of host and device drivers with pull-ups.
    assign ps2_clk_i  = ~(ps2_clk_oe_o | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe_o | dev_data_low);

    always #5 clk_i = ~clk_i;

    // Event monitors, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (ack_o) n_ack <= n_ack + 1;
        if (err_o) n_err <= n_err + 1;
        if (s_axis_tready_o && busy_o) n_rdy_busy <= n_rdy_busy + 1;
    end

    always @(posedge clk_i) begin
        if (s_axis_tvalid_i && s_axis_tready_o) begin
            acc_n    <= acc_n + 1;
            acc_last <= s_axis_tdata_i;
        end
    end

    // Expected 11-bit frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = d[k];
            ones += int'(d[k]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        @(negedge clk_i);
        s_axis_tvalid_i = 1'b1;
        s_axis_tdata_i  = b;
        w = 0;
        while (!s_axis_tready_o && w < 20000) begin
            @(negedge clk_i);
            w++;
        end
        chk("tready_wait", int'(s_axis_tready_o), 1);
        @(posedge clk_i);
        #1;
    endtask

    // Device side of one frame. abort_edge>0 stops right after that falling edge.
    task automatic dev_frame(input bit nack, input int half, input int abort_edge,
                             output logic [10:0] bits, output int inh_len, output int req_len);
        int w;
        bits = '0;
        inh_len = 0;
        req_len = 0;
        @(negedge clk_i);
        w = 0;
        while (!ps2_clk_oe_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("inhibit_start", int'(ps2_clk_oe_o), 1);
        while (ps2_clk_oe_o && !ps2_data_oe_o && inh_len < INH + 100) begin
            @(negedge clk_i);
            inh_len++;
        end
        while (ps2_clk_oe_o && ps2_data_oe_o && req_len < 10) begin
            @(negedge clk_i);
            req_len++;
        end
        for (int i = 1; i <= 11; i++) begin
            repeat (half) @(negedge clk_i);
            bits[i-1] = ps2_data_i;
            if (i == 11 && !nack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge clk_i);
            end
            dev_clk_low = 1'b1;
            if (i == abort_edge) begin
                repeat (6) @(negedge clk_i);
                return;
            end
            repeat (half) @(negedge clk_i);
            dev_clk_low = 1'b0;
        end
        repeat (half) @(negedge clk_i);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk(tag, int'(busy_o), 0);
    endtask

    // Full normal transfer with ACK, checking frame, inhibit/request lengths and pulses.
    task automatic xfer_ok(input string tag, input logic [7:0] b, input int half);
        logic [10:0] bits;
        int inh, req, a0, e0;
        a0 = n_ack;
        e0 = n_err;
        send(b);
        s_axis_tvalid_i = 1'b0;
        chk({tag, "_accepted"}, int'(acc_last), int'(b));
        dev_frame(1'b0, half, 0, bits, inh, req);
        repeat (5) @(negedge clk_i);
        chk({tag, "_frame"}, int'(bits), int'(ref_frame(b)));
        chk({tag, "_inhibit_len"}, inh, INH);
        chk({tag, "_req_len"}, req, 1);
        chk({tag, "_ack"}, n_ack - a0, 1);
        chk({tag, "_err"}, n_err - e0, 0);
        wait_idle({tag, "_idle"});
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [10:0] bits;
        int inh, req, a0, e0, w, k;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_tready", int'(s_axis_tready_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_oe", int'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        chk("rst_pulses", int'({ack_o, err_o}), 0);
        rst_i = 1'b0;
        #1;
        chk("tready_before_edge", int'(s_axis_tready_o), 0);
        @(negedge clk_i);
        chk("tready_first_edge", int'(s_axis_tready_o), 1);

        // Line activity in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (6) @(negedge clk_i);
            dev_clk_low = 1'b0;
            repeat (6) @(negedge clk_i);
        end
        chk("idle_edges_busy", int'(busy_o), 0);

        // Directed frames and parity
        xfer_ok("ED", 8'hED, 10);
        xfer_ok("07", 8'h07, 10);
        xfer_ok("00", 8'h00, 12);

        // Randomized bytes and device clock rates
        for (int r = 0; r < 3; r++) begin
            rb = 8'($urandom_range(0, 255));
            xfer_ok("rand", rb, int'($urandom_range(8, 14)));
        end

        // Timeout: device never clocks after the request
        e0 = n_err;
        send(8'h42);
        s_axis_tvalid_i = 1'b0;
        w = 0;
        while (!ps2_clk_oe_o && w < 50) begin @(negedge clk_i); w++; end
        while (ps2_clk_oe_o && w < INH + 100) begin @(negedge clk_i); w++; end
        k = 0;
        while (!err_o && k < TO + 50) begin @(negedge clk_i); k++; end
        chk("timeout_cycles", k, TO);
        chk("timeout_released", int'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        wait_idle("timeout_idle");
        chk("timeout_tready", int'(s_axis_tready_o), 1);
        chk("timeout_err_count", n_err - e0, 1);

        // NACK handling
`ifdef PS2_TX_RESEND_EN
        a0 = n_ack; e0 = n_err;
        send(8'h5A);
        s_axis_tvalid_i = 1'b0;
        dev_frame(1'b1, 10, 0, bits, inh, req);
        dev_frame(1'b0, 10, 0, bits, inh, req);
        repeat (5) @(negedge clk_i);
        chk("resend_inhibit", inh, INH);
        chk("resend_frame", int'(bits), int'(ref_frame(8'h5A)));
        chk("resend_ack", n_ack - a0, 1);
        chk("resend_no_err", n_err - e0, 0);
        wait_idle("resend_idle");
        a0 = n_ack; e0 = n_err;
        send(8'hA5);
        s_axis_tvalid_i = 1'b0;
        dev_frame(1'b1, 10, 0, bits, inh, req);
        dev_frame(1'b1, 10, 0, bits, inh, req);
        repeat (5) @(negedge clk_i);
        chk("double_nack_err", n_err - e0, 1);
        chk("double_nack_ack", n_ack - a0, 0);
        wait_idle("double_nack_idle");
        repeat (20) @(negedge clk_i);
        chk("double_nack_no_retry", int'({busy_o, ps2_clk_oe_o}), 0);
`else
        a0 = n_ack; e0 = n_err;
        send(8'h5A);
        s_axis_tvalid_i = 1'b0;
        dev_frame(1'b1, 10, 0, bits, inh, req);
        repeat (5) @(negedge clk_i);
        chk("nack_frame", int'(bits), int'(ref_frame(8'h5A)));
        chk("nack_err", n_err - e0, 1);
        chk("nack_ack", n_ack - a0, 0);
        wait_idle("nack_idle");
        repeat (20) @(negedge clk_i);
        chk("nack_no_retry", int'({busy_o, ps2_clk_oe_o}), 0);
`endif

        // Asynchronous reset at falling edge 5, then a normal byte
        send(8'h99);
        s_axis_tvalid_i = 1'b0;
        dev_frame(1'b0, 10, 5, bits, inh, req);
        #1;
        rst_i = 1'b1;
        #1;
        chk("abort_oe", int'({ps2_clk_oe_o, ps2_data_oe_o}), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_tready", int'(s_axis_tready_o), 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_tready_after", int'(s_axis_tready_o), 1);
        xfer_ok("F4", 8'hF4, 10);

        // tvalid held through a transfer; 0xFF taken in the first IDLE cycle
        a0 = n_rdy_busy;
        send(8'h3C);
        s_axis_tdata_i = 8'hFF;
        dev_frame(1'b0, 10, 0, bits, inh, req);
        chk("held_first_frame", int'(bits), int'(ref_frame(8'h3C)));
        w = 0;
        while (busy_o && w < 200) begin @(negedge clk_i); w++; end
        chk("held_idle_tready", int'(s_axis_tready_o), 1);
        @(negedge clk_i);
        chk("held_accept_busy", int'(busy_o), 1);
        chk("held_accept_data", int'(acc_last), 8'hFF);
        s_axis_tvalid_i = 1'b0;
        dev_frame(1'b0, 10, 0, bits, inh, req);
        repeat (5) @(negedge clk_i);
        chk("held_ff_frame", int'(bits), int'(ref_frame(8'hFF)));
        wait_idle("held_idle");
        chk("tready_never_busy", n_rdy_busy - a0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_tx_axis.md
PS2_TX_AXIS -- requirements
Module: ps2_tx_axis

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, which is the clock-inhibit length in clk_i cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, which is the maximum number of clk_i cycles allowed from clock release to the 11th falling edge.
REQ-003 SHALL have port clk_i, input, 1 bit: system clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tvalid_i, input, 1 bit: command byte valid.
REQ-006 SHALL have port s_axis_tready_o, output, 1 bit: block can accept a byte.
REQ-007 SHALL have port s_axis_tdata_i, input, 8 bits: command byte sent to the device.
REQ-008 SHALL have port ps2_clk_i, input, 1 bit: raw PS/2 clock line.
REQ-009 SHALL have port ps2_data_i, input, 1 bit: raw PS/2 data line.
REQ-010 SHALL have port ps2_clk_oe_o, output, 1 bit: 1 pulls the clock line low (open-drain).
REQ-011 SHALL have port ps2_data_oe_o, output, 1 bit: 1 pulls the data line low (open-drain).
REQ-012 SHALL have port busy_o, output, 1 bit: a transfer is in progress; the receiver must ignore the line.
REQ-013 SHALL have port ack_o, output, 1 bit: one-cycle pulse when the device ACKs.
REQ-014 SHALL have port err_o, output, 1 bit: one-cycle pulse on NACK or timeout.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_data_i through 2-FF synchronizers; a falling edge is synchronized clock high in the previous cycle and low in the current cycle.
REQ-016 SHALL use states IDLE, INHIBIT, REQ, SHIFT, ACK and WAIT_IDLE.
REQ-017 SHALL assert s_axis_tready_o only in IDLE; it SHALL capture s_axis_tdata_i on tvalid&tready and enter INHIBIT on the next cycle.
REQ-018 SHALL hold ps2_clk_oe_o=1 and ps2_data_oe_o=0 in INHIBIT for exactly INHIBIT_CYCLES cycles, then enter REQ.
REQ-019 SHALL hold ps2_clk_oe_o=1 and ps2_data_oe_o=1 in REQ for one cycle, then enter SHIFT.
REQ-020 SHALL in SHIFT hold ps2_clk_oe_o=0 and initially ps2_data_oe_o=1 (start bit 0).
REQ-021 SHALL, in SHIFT, on falling edges 1..8 set ps2_data_oe_o = ~D[n-1], sending LSB first.
REQ-022 SHALL, on falling edge 9, set ps2_data_oe_o = ~P, where P = ~^D (odd parity).
REQ-023 SHALL, on falling edge 10, set ps2_data_oe_o=0 (stop bit, line released) and enter ACK.
REQ-024 SHALL, in ACK, sample synchronized data on falling edge 11: low -> pulse ack_o; high -> NACK handling per REQ-033/034; either case then enters WAIT_IDLE.
REQ-025 SHALL leave WAIT_IDLE for IDLE once synchronized clock and data are both high for 1 cycle.
REQ-026 SHALL, when the timeout counter (started on entry to SHIFT, cleared on ACK exit) reaches TIMEOUT_CYCLES, release both lines, pulse err_o and go to WAIT_IDLE.
REQ-027 SHALL assert busy_o in every state except IDLE.
REQ-028 SHALL ignore s_axis_tvalid_i while busy; a held tvalid is accepted on the first IDLE cycle.
REQ-029 SHALL ignore ps2 edges in IDLE, INHIBIT and REQ.
REQ-030 SHALL use a 4-bit edge counter that is exactly 0 on SHIFT entry.

Reset
REQ-031 SHALL, on rst_i assertion, immediately (asynchronously) set state IDLE, ps2_clk_oe_o=0, ps2_data_oe_o=0, busy_o=0, ack_o=0, err_o=0, s_axis_tready_o=0 and counters=0, including mid-transfer.
REQ-032 SHALL drive s_axis_tready_o=1 from the first clk_i edge after rst_i deasserts.

Configuration
REQ-033 SHALL, with PS2_TX_RESEND_EN defined, restart a NACKed byte once from INHIBIT (via WAIT_IDLE) without pulsing err_o, and pulse err_o only on a second NACK; timeout never retries.
REQ-034 SHALL, without PS2_TX_RESEND_EN, pulse err_o on the first NACK with no retry.

Verification
REQ-035 SHALL cover: send 0xED, device model ACKs -> clk_oe high for 5000 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop, one ack_o pulse, err_o=0.
REQ-036 SHALL cover: send 0x07 -> parity bit 0; send 0x00 -> parity bit 1; data_oe=0 after edge 10.
REQ-037 SHALL cover: device holds clock high after REQ -> err_o pulses exactly TIMEOUT_CYCLES cycles after SHIFT entry; lines released; tready returns.
REQ-038 SHALL cover: device NACKs (data high on edge 11) -> err_o pulses without the macro; with PS2_TX_RESEND_EN, a second INHIBIT/REQ/SHIFT sequence occurs, and err_o pulses only if the device NACKs again.
REQ-039 SHALL cover: rst_i asserted at edge 5 of SHIFT -> both oe outputs are 0 in the same cycle, busy_o=0, and the next byte 0xF4 completes normally.
REQ-040 SHALL cover: tvalid held with 0xFF during a transfer -> tready=0 until WAIT_IDLE clears, then 0xFF is accepted in the first IDLE cycle.
